// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// N-bit adder/subtractor whose ripple carry chain is cut into STAGES equal
// slices with one register stage per slice. Each beat carries its operands
// and partial result down the pipe (skewed pipeline), so stage k only ever
// ripples W = N/STAGES bits.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand beat present
//   in_ready  block accepts a beat this cycle (= !out_valid || out_ready)
//   a, b      operands (N bits)
//   cin       carry-in (borrow-in when sub=1)
//   sub       0 = a + b + cin, 1 = a - b - cin
//   out_valid result beat present
//   out_ready downstream accepts result
//   sum       result (N bits)
//   cout      carry-out of MSB (for subtract: 1 = no borrow)
//   ovf       two's-complement signed overflow
module pipelined_addsub #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    generate
        if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
            $error("pipelined_addsub: N must be >= 2 and a multiple of STAGES (1 <= STAGES <= N)");
        end
    endgenerate

    // Per-stage pipeline registers: valid, operands (b already inverted for
    // subtract), partial result and the carry out of that stage's slice.
    logic         v_q   [STAGES];
    logic [N-1:0] a_q   [STAGES];
    logic [N-1:0] b_q   [STAGES];
    logic [N-1:0] s_q   [STAGES];
    logic         c_q   [STAGES];
    logic         ovf_q;

    // Values presented to each stage's input and what that stage computes.
    logic         v_in_w  [STAGES];
    logic [N-1:0] a_in_w  [STAGES];
    logic [N-1:0] b_in_w  [STAGES];
    logic [N-1:0] s_in_w  [STAGES];
    logic         c_in_w  [STAGES];
    logic [W:0]   slice_w [STAGES];
    logic [N-1:0] s_nxt_w [STAGES];
    logic         c_nxt_w [STAGES];
    logic         ovf_nxt;
    logic         advance;

    // The whole pipe moves as one: it advances whenever the output register
    // is empty or being drained. Bubbles move along with real beats.
    assign advance   = !v_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Stage 0 resolves the operation: subtract is a + ~b + ~cin, so b and
    // cin are inverted once here and every later slice just adds.
    always_comb begin
        v_in_w[0] = in_valid;
        a_in_w[0] = a;
        b_in_w[0] = sub ? ~b : b;
        c_in_w[0] = cin ^ sub;
        s_in_w[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in_w[k] = v_q[k-1];
            a_in_w[k] = a_q[k-1];
            b_in_w[k] = b_q[k-1];
            c_in_w[k] = c_q[k-1];
            s_in_w[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_w[k] = {1'b0, a_in_w[k][k*W +: W]}
                       + {1'b0, b_in_w[k][k*W +: W]}
                       + {{W{1'b0}}, c_in_w[k]};
            s_nxt_w[k] = s_in_w[k];
            s_nxt_w[k][k*W +: W] = slice_w[k][W-1:0];
            c_nxt_w[k] = slice_w[k][W];
        end
        // Carry-into-MSB xor carry-out-of-MSB is the same as: both addend
        // sign bits agree and the result sign differs from them.
        ovf_nxt = (a_in_w[STAGES-1][N-1] == b_in_w[STAGES-1][N-1])
               && (s_nxt_w[STAGES-1][N-1] != a_in_w[STAGES-1][N-1]);
    end

    // Data registers only load when a real beat enters the stage, so the
    // outputs keep their last values across bubbles and stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in_w[k];
                if (v_in_w[k]) begin
                    a_q[k] <= a_in_w[k];
                    b_q[k] <= b_in_w[k];
                    s_q[k] <= s_nxt_w[k];
                    c_q[k] <= c_nxt_w[k];
                end
            end
            if (v_in_w[STAGES-1]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
// Self-checking bench for pipelined_addsub. The main instance (N=16,
// STAGES=4) runs directed and backpressured scenarios; three further
// instances (16/1, 16/16, 32/8) rerun latency and a random stream.
// Expected results are queued when a beat is accepted and popped when the
// DUT hands a result downstream.
module tb_pipelined_addsub;

    localparam int N = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [N+1:0] exp_q[$];
    logic         sweep_go     = 1'b0;
    int           sweep_done   = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.N(N), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference model on plain integers: returns {ovf, cout, sum[63:0]}.
    // Unsigned math gives sum/cout, signed math gives overflow.
    function automatic logic [65:0] model_w(input int w, input longint ua, input longint ub,
                                            input logic ci, input logic sb);
        longint m, us, sa, sbv, ss, hi, lo;
        logic   co, ov;
        m = longint'(1) << w;
        if (sb) us = ua - ub - longint'(ci);
        else    us = ua + ub + longint'(ci);
        co  = sb ? (us >= 0) : (us >= m);
        sa  = ua[w-1] ? ua - m : ua;
        sbv = ub[w-1] ? ub - m : ub;
        if (sb) ss = sa - sbv - longint'(ci);
        else    ss = sa + sbv + longint'(ci);
        hi = m / 2 - 1;
        lo = -(m / 2);
        ov = (ss > hi) || (ss < lo);
        return {ov, co, 64'(us & (m - 1))};
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
    endtask

    // Drives one beat into an otherwise idle pipe and waits (bounded) for
    // the result; lat counts edges from the accepting edge to out_valid.
    task automatic send_beat(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc,
                             input logic ts, output logic [N-1:0] osum, output logic oc,
                             output logic oo, output int lat);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        cin       = tc;
        sub       = ts;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        osum = sum;
        oc   = cout;
        oo   = ovf;
    endtask

    task automatic test_reset();
        logic [N-1:0] s;
        logic         c, o;
        int           lat, stale;
        logic [N+1:0] e;
        rst = 1'b0;
        idle();
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, cout, ovf, sum} !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got v=%b c=%b o=%b sum=%h rdy=%b, expected all 0 and rdy=1",
                     out_valid, cout, ovf, sum, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Three beats in, then hold the output so the first one is parked there.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = N'(16'h1111 * (i + 1));
            b = N'(16'h2222 * (i + 1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || sum !== 16'h3333) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_beat: got v=%b sum=%h, expected v=1 sum=3333", out_valid, sum);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, cout, ovf} !== 3'b000 || sum !== 16'h0000 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midstream_reset: got v=%b c=%b o=%b sum=%h rdy=%b, expected 0 0 0 0000 1",
                     out_valid, cout, ovf, sum, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (stale !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stale_after_reset: got %0d stale beats, expected 0", stale);
        end
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b0, 16'h0124});
        send_beat(16'h0100, 16'h0023, 1'b1, 1'b0, s, c, o, lat);
        tests_run++;
        if (lat !== S) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_latency: got %0d expected %0d", lat, S);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_result: got %h expected %h", {o, c, s}, e);
        end
    endtask

    task automatic test_full_carry();
        logic [N-1:0] s;
        logic         c, o;
        int           lat;
        logic [N+1:0] e;
        exp_q.push_back({1'b0, 1'b1, 16'h0000});
        send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
        tests_run++;
        if (lat !== S) begin
            tests_failed++;
            $display("[TB] FAIL full_carry_latency: got %0d expected %0d", lat, S);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL full_carry: got ovf,cout,sum=%h expected %h", {o, c, s}, e);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] s;
        logic         c, o;
        int           lat;
        logic [N+1:0] e;
        exp_q.push_back({1'b1, 1'b0, 16'h8000});
        send_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL add_overflow: got %h expected %h", {o, c, s}, e);
        end
        exp_q.push_back({1'b1, 1'b1, 16'h7FFF});
        send_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL sub_overflow: got %h expected %h", {o, c, s}, e);
        end
    endtask

    task automatic test_subtract();
        logic [N-1:0] s;
        logic         c, o;
        int           lat;
        logic [N+1:0] e;
        exp_q.push_back({1'b0, 1'b0, 16'hFFFD});
        send_beat(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat);
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL sub_borrow: got %h expected %h", {o, c, s}, e);
        end
        exp_q.push_back({1'b0, 1'b1, 16'h0000});
        send_beat(16'h1234, 16'h1234, 1'b0, 1'b1, s, c, o, lat);
        e = exp_q.pop_front();
        tests_run++;
        if ({o, c, s} !== e) begin
            tests_failed++;
            $display("[TB] FAIL sub_equal: got %h expected %h", {o, c, s}, e);
        end
    endtask

    task automatic test_back_to_back();
        int           sent, got, cycles;
        logic         stall;
        logic [N+1:0] held, e;
        logic [65:0]  r;
        sent = 0; got = 0; cycles = 0; stall = 1'b0; held = '0;
        exp_q.delete();
        // Let the last directed result drain first.
        idle();
        @(posedge clk); #1;
        while ((sent < 16 || exp_q.size() != 0) && cycles < 500) begin
            in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
            a         = N'($urandom());
            b         = N'($urandom());
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall) begin
                tests_run++;
                if ({out_valid, ovf, cout, sum} !== {1'b1, held}) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_stable: got v=%b %h expected v=1 %h",
                             out_valid, {ovf, cout, sum}, held);
                end
            end
            tests_run++;
            if (in_ready !== (!out_valid || out_ready)) begin
                tests_failed++;
                $display("[TB] FAIL in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_extra: got unexpected result %h, expected none", {ovf, cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if ({ovf, cout, sum} !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL stream_result%0d: got %h expected %h", got, {ovf, cout, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = model_w(N, longint'(a), longint'(b), cin, sub);
                exp_q.push_back({r[65], r[64], r[N-1:0]});
                sent++;
            end
            stall = out_valid && !out_ready;
            held  = {ovf, cout, sum};
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (got !== 16 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d results (%0d pending), expected 16", got, exp_q.size());
        end
        idle();
    endtask

    // Parameter sweep: each configuration gets its own DUT and stream.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SN = (g == 2) ? 32 : 16;
        localparam int SS = (g == 0) ? 1 : (g == 1) ? 16 : 8;

        logic          srst, siv, sirdy, scin, ssub, sov, sordy, scout, sovf;
        logic [SN-1:0] sa, sb, ssum;
        logic [SN+1:0] sq[$];

        pipelined_addsub #(.N(SN), .STAGES(SS)) u_dut (
            .clk       (clk),
            .rst       (srst),
            .in_valid  (siv),
            .in_ready  (sirdy),
            .a         (sa),
            .b         (sb),
            .cin       (scin),
            .sub       (ssub),
            .out_valid (sov),
            .out_ready (sordy),
            .sum       (ssum),
            .cout      (scout),
            .ovf       (sovf)
        );

        initial begin
            int            lat, sent, got, cyc;
            logic [65:0]   r;
            logic [SN+1:0] e;
            srst = 1'b0; siv = 1'b0; sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0; sordy = 1'b1;
            #1 srst = 1'b1;
            wait (sweep_go);
            @(posedge clk); #1;
            srst = 1'b0;
            siv = 1'b1; sa = '1; sb = SN'(1);
            @(posedge clk); #1;
            siv = 1'b0;
            lat = 1;
            while (!sov && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            tests_run++;
            if (lat !== SS) begin
                tests_failed++;
                $display("[TB] FAIL sweep%0d_latency: got %0d expected %0d", g, lat, SS);
            end
            r = model_w(SN, longint'({SN{1'b1}}), longint'(1), 1'b0, 1'b0);
            e = {r[65], r[64], r[SN-1:0]};
            tests_run++;
            if ({sovf, scout, ssum} !== e) begin
                tests_failed++;
                $display("[TB] FAIL sweep%0d_full_carry: got %h expected %h", g, {sovf, scout, ssum}, e);
            end
            @(posedge clk); #1;
            sent = 0; got = 0; cyc = 0;
            while ((sent < 16 || sq.size() != 0) && cyc < 1000) begin
                siv   = (sent < 16) && ($urandom_range(0, 3) != 0);
                sa    = SN'($urandom());
                sb    = SN'($urandom());
                scin  = 1'($urandom_range(0, 1));
                ssub  = 1'($urandom_range(0, 1));
                sordy = ($urandom_range(0, 2) != 0);
                #1;
                if (sov && sordy) begin
                    tests_run++;
                    if (sq.size() == 0) begin
                        tests_failed++;
                        $display("[TB] FAIL sweep%0d_extra: got unexpected result, expected none", g);
                    end else begin
                        e = sq.pop_front();
                        got++;
                        if ({sovf, scout, ssum} !== e) begin
                            tests_failed++;
                            $display("[TB] FAIL sweep%0d_result%0d: got %h expected %h",
                                     g, got, {sovf, scout, ssum}, e);
                        end
                    end
                end
                if (siv && sirdy) begin
                    r = model_w(SN, longint'(sa), longint'(sb), scin, ssub);
                    sq.push_back({r[65], r[64], r[SN-1:0]});
                    sent++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            tests_run++;
            if (got !== 16 || sq.size() != 0) begin
                tests_failed++;
                $display("[TB] FAIL sweep%0d_count: got %0d results, expected 16", g, got);
            end
            siv = 1'b0;
            sweep_done++;
        end
    end

    initial begin
        test_reset();
        test_full_carry();
        test_overflow();
        test_subtract();
        test_back_to_back();
        sweep_go = 1'b1;
        for (int i = 0; i < 5000 && sweep_done < 3; i++) @(posedge clk);
        tests_run++;
        if (sweep_done !== 3) begin
            tests_failed++;
            $display("[TB] FAIL sweep_timeout: got %0d configs done, expected 3", sweep_done);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
